// File: rtl/reg_window_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_window_pkg
// Brief    : Shared types and sizing for the register-window sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package reg_window_pkg;

  localparam int WIN_W   = 2;
  localparam int NUM_WIN = 4;
  localparam int RES_MAX = 3;
  localparam int DATA_W  = 16;
  localparam int RES_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPILL_RD = 3'd1,
    ST_SPILL_W0 = 3'd2,
    ST_SPILL_W1 = 3'd3,
    ST_FILL_R0  = 3'd4,
    ST_FILL_R1  = 3'd5
  } state_e;

  // Window arithmetic wraps modulo the number of windows; delta may be negative.
  function automatic logic [WIN_W-1:0] win_add(input logic [WIN_W-1:0] w, input int delta);
    return WIN_W'((int'(w) + delta + NUM_WIN) % NUM_WIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spill_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : spill_mem_if
// Brief    : Single-transaction req/ack memory port shared by spill and fill.
// Revision : 1.0 - initial release
// ============================================================================
module spill_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ack,
  output logic              o_req,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_xfer
);

  logic              req_q,   req_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // A new request is only accepted while idle, so address and data stay
  // frozen for the whole time req is high.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (req_q && i_ack) begin
      req_d = 1'b0;
    end else if (!req_q && i_start) begin
      req_d   = 1'b1;
      we_d    = i_we;
      addr_d  = i_addr;
      wdata_d = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_req   = req_q;
  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_xfer  = req_q & i_ack;

endmodule
`default_nettype wire

// File: rtl/reg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_window_ctrl
// Brief    : CALL/RET window sequencer with spill/fill to a memory stack.
// Revision : 1.0 - initial release
// ============================================================================
module reg_window_ctrl
  import reg_window_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SPILL_BASE = 16'h0100,
  parameter int                MAX_SPILL  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call,
  input  logic              ret,
  output logic [WIN_W-1:0]  win,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rf_own,
  output logic [WIN_W-1:0]  rf_window,
  output logic [1:0]        rf_ri,
  output logic [1:0]        rf_rj,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int               CNT_W     = $clog2(MAX_SPILL + 1);
  localparam logic [CNT_W-1:0] SPILL_LIM = CNT_W'(MAX_SPILL);
  localparam logic [RES_W-1:0] RES_LIM   = RES_W'(RES_MAX);

  state_e             state_q,    state_d;
  logic [WIN_W-1:0]   win_q,      win_d;
  logic [RES_W-1:0]   resident_q, resident_d;
  logic [CNT_W-1:0]   spilled_q,  spilled_d;
  logic [ADDR_W-1:0]  sp_q,       sp_d;
  logic [DATA_W-1:0]  r0_q,       r0_d;
  logic [DATA_W-1:0]  r1_q,       r1_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;

  logic               mem_start;
  logic               mem_start_we;
  logic [ADDR_W-1:0]  mem_start_addr;
  logic [DATA_W-1:0]  mem_start_wdata;
  logic               mem_xfer;

  always_comb begin
    state_d         = state_q;
    win_d           = win_q;
    resident_d      = resident_q;
    spilled_d       = spilled_q;
    sp_d            = sp_q;
    r0_d            = r0_q;
    r1_d            = r1_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    mem_start       = 1'b0;
    mem_start_we    = 1'b0;
    mem_start_addr  = sp_q;
    mem_start_wdata = r0_q;
    rf_own          = 1'b0;
    rf_window       = '0;
    rf_ri           = 2'd0;
    rf_rj           = 2'd0;
    rf_we           = 1'b0;
    rf_wdata        = '0;

    case (state_q)
      ST_IDLE: begin
        if (call && ret) begin
          err_d = 1'b1;
        end else if (call) begin
          if (resident_q < RES_LIM) begin
            win_d      = win_add(win_q, 1);
            resident_d = resident_q + RES_W'(1);
            done_d     = 1'b1;
          end else if (spilled_q < SPILL_LIM) begin
            state_d = ST_SPILL_RD;
          end else begin
            err_d = 1'b1;
          end
        end else if (ret) begin
          if (resident_q > RES_W'(1)) begin
            win_d      = win_add(win_q, -1);
            resident_d = resident_q - RES_W'(1);
            done_d     = 1'b1;
          end else if (spilled_q != '0) begin
            sp_d    = sp_q - ADDR_W'(2);
            state_d = ST_FILL_R0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // The oldest resident window is two behind; its R0/R1 are about to be
      // aliased by the R2/R3 of the window being entered.
      ST_SPILL_RD: begin
        rf_own    = 1'b1;
        rf_window = win_add(win_q, -2);
        rf_ri     = 2'd0;
        rf_rj     = 2'd1;
        r0_d      = rf_rdata1;
        r1_d      = rf_rdata2;
        state_d   = ST_SPILL_W0;
      end

      ST_SPILL_W0: begin
        mem_start       = !mem_req;
        mem_start_we    = 1'b1;
        mem_start_addr  = sp_q;
        mem_start_wdata = r0_q;
        if (mem_xfer) begin
          state_d = ST_SPILL_W1;
        end
      end

      ST_SPILL_W1: begin
        mem_start       = !mem_req;
        mem_start_we    = 1'b1;
        mem_start_addr  = sp_q + ADDR_W'(1);
        mem_start_wdata = r1_q;
        if (mem_xfer) begin
          sp_d      = sp_q + ADDR_W'(2);
          spilled_d = spilled_q + CNT_W'(1);
          win_d     = win_add(win_q, 1);
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_FILL_R0: begin
        mem_start      = !mem_req;
        mem_start_addr = sp_q;
        if (mem_xfer) begin
          rf_own    = 1'b1;
          rf_we     = 1'b1;
          rf_window = win_add(win_q, -1);
          rf_ri     = 2'd0;
          rf_wdata  = mem_rdata;
          state_d   = ST_FILL_R1;
        end
      end

      ST_FILL_R1: begin
        mem_start      = !mem_req;
        mem_start_addr = sp_q + ADDR_W'(1);
        if (mem_xfer) begin
          rf_own    = 1'b1;
          rf_we     = 1'b1;
          rf_window = win_add(win_q, -1);
          rf_ri     = 2'd1;
          rf_wdata  = mem_rdata;
          spilled_d = spilled_q - CNT_W'(1);
          win_d     = win_add(win_q, -1);
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      resident_q <= RES_W'(1);
      spilled_q  <= '0;
      sp_q       <= SPILL_BASE;
      r0_q       <= '0;
      r1_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      resident_q <= resident_d;
      spilled_q  <= spilled_d;
      sp_q       <= sp_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  spill_mem_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_if (
    .clk     (clk),
    .rst     (rst),
    .i_start (mem_start),
    .i_we    (mem_start_we),
    .i_addr  (mem_start_addr),
    .i_wdata (mem_start_wdata),
    .i_ack   (mem_ack),
    .o_req   (mem_req),
    .o_we    (mem_we),
    .o_addr  (mem_addr),
    .o_wdata (mem_wdata),
    .o_xfer  (mem_xfer)
  );

  assign win  = win_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_window_ctrl
// Brief    : Directed and randomized checks of reg_window_ctrl against a stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_window_ctrl;

  localparam int MAX_SP = 8;

  logic        clk = 1'b0;
  logic        rst, call, ret;
  logic [1:0]  win, rf_window, rf_ri, rf_rj;
  logic        busy, done, err, rf_own, rf_we;
  logic [15:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  reg_window_ctrl #(
    .ADDR_W     (16),
    .SPILL_BASE (16'h0100),
    .MAX_SPILL  (MAX_SP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call      (call),
    .ret       (ret),
    .win       (win),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rf_own    (rf_own),
    .rf_window (rf_window),
    .rf_ri     (rf_ri),
    .rf_rj     (rf_rj),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Physical register file: window w, logical r -> physical (2w+r) mod 8.
  logic [15:0] phys [8];
  logic        pl_en = 1'b0;
  int          pl_idx = 0;
  logic [15:0] pl_data = '0;

  function automatic int pidx(input logic [1:0] w, input logic [1:0] r);
    return (2 * int'(w) + int'(r)) % 8;
  endfunction

  assign rf_rdata1 = phys[pidx(rf_window, rf_ri)];
  assign rf_rdata2 = phys[pidx(rf_window, rf_rj)];

  always @(posedge clk) begin
    if (pl_en) phys[pl_idx] <= pl_data;
    if (rf_we) phys[pidx(rf_window, rf_ri)] <= rf_wdata;
  end

  // Memory responder with programmable ack latency and a log of completed transfers.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } tx_t;

  tx_t         tx_q [$];
  logic [15:0] mem [logic [15:0]];
  int          ack_delay = 0;
  int          wait_cnt;
  bit          have_cap;
  logic [32:0] cap;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    have_cap  = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst !== 1'b0 || mem_req !== 1'b1) begin
        wait_cnt = 0;
        have_cap = 1'b0;
      end else begin
        if (!have_cap) begin
          cap      = {mem_we, mem_addr, mem_wdata};
          have_cap = 1'b1;
        end else begin
          chk("mem_stable", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, cap});
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            tx_q.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
            tx_q.push_back({1'b0, mem_addr, mem_rdata});
          end
          wait_cnt = 0;
          have_cap = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Reference model: window position, resident count and a stack of saved R0/R1 pairs.
  int          m_win, m_res, m_spill;
  logic [15:0] m_sp;
  logic [31:0] m_stack [$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_win   = 0;
    m_res   = 1;
    m_spill = 0;
    m_sp    = 16'h0100;
    m_stack.delete();
  endtask

  task automatic preload(input int idx, input logic [15:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst  = 1'b1;
    call = 1'b0;
    ret  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tx_q.delete();
  endtask

  // kind: 0 plain move, 1 spill, 2 fill, 3 rejected
  task automatic op(input logic c, input logic r, input int poke);
    int          kind;
    int          ow;
    int          n;
    bit          err_seen;
    logic [15:0] e0, e1, sa;
    logic [31:0] pair;
    kind = 3;
    e0   = '0;
    e1   = '0;
    sa   = '0;
    pair = '0;
    tx_q.delete();
    if (c && r) begin
      kind = 3;
    end else if (c) begin
      if (m_res < 3) begin
        kind = 0; m_res++; m_win = (m_win + 1) % 4;
      end else if (m_spill < MAX_SP) begin
        kind = 1;
        ow   = (m_win + 2) % 4;
        e0   = phys[(2 * ow) % 8];
        e1   = phys[(2 * ow + 1) % 8];
        sa   = m_sp;
        m_stack.push_back({e0, e1});
        m_sp = m_sp + 16'd2;
        m_spill++;
        m_win = (m_win + 1) % 4;
      end
    end else if (r) begin
      if (m_res > 1) begin
        kind = 0; m_res--; m_win = (m_win + 3) % 4;
      end else if (m_spill > 0) begin
        kind = 2;
        m_sp = m_sp - 16'd2;
        sa   = m_sp;
        pair = m_stack.pop_back();
        m_spill--;
        m_win = (m_win + 3) % 4;
      end
    end

    tick();
    call = c;
    ret  = r;
    tick();
    call = 1'b0;
    ret  = 1'b0;

    if (kind == 0 || kind == 3) begin
      chk("done_pulse", {63'd0, done}, {63'd0, kind == 0});
      chk("err_pulse",  {63'd0, err},  {63'd0, kind == 3});
      chk("busy_idle",  {63'd0, busy}, 64'd0);
      chk("win",        {62'd0, win},  64'(m_win));
      chk("no_mem",     {63'd0, mem_req}, 64'd0);
    end else begin
      chk("busy_start", {63'd0, busy}, 64'd1);
      err_seen = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        if (poke > 0 && n == poke) begin
          chk("busy_at_poke", {63'd0, busy}, 64'd1);
          call = 1'b1;
        end else begin
          call = 1'b0;
        end
        if (err === 1'b1) err_seen = 1'b1;
        tick();
        n++;
      end
      call = 1'b0;
      chk("op_timeout", 64'(n < 200), 64'd1);
      chk("done_end",   {63'd0, done}, 64'd1);
      chk("no_err_busy", {63'd0, err_seen}, 64'd0);
      chk("win_end",    {62'd0, win}, 64'(m_win));
      chk("tx_count",   64'(tx_q.size()), 64'd2);
      if (tx_q.size() == 2) begin
        if (kind == 1) begin
          chk("spill_w0", {31'd0, tx_q[0]}, {31'd0, 1'b1, sa, e0});
          chk("spill_w1", {31'd0, tx_q[1]}, {31'd0, 1'b1, sa + 16'd1, e1});
        end else begin
          chk("fill_r0_addr", {47'd0, tx_q[0].we, tx_q[0].addr}, {47'd0, 1'b0, sa});
          chk("fill_r1_addr", {47'd0, tx_q[1].we, tx_q[1].addr}, {47'd0, 1'b0, sa + 16'd1});
          chk("fill_rf_r0", {48'd0, phys[(2 * m_win) % 8]},     {48'd0, pair[31:16]});
          chk("fill_rf_r1", {48'd0, phys[(2 * m_win + 1) % 8]}, {48'd0, pair[15:0]});
        end
      end
    end
  endtask

  initial begin
    int n;
    int sel;
    rst  = 1'b1;
    call = 1'b0;
    ret  = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) preload(i, 16'($urandom));
    do_reset();

    chk("reset_outputs",
        {1'b0, win, busy, done, err, rf_own, rf_window, rf_ri, rf_rj, rf_we, rf_wdata,
         mem_req, mem_we, mem_addr, mem_wdata}, 64'd0);

    // Underflow and simultaneous call/ret.
    op(1'b0, 1'b1, 0);
    op(1'b1, 1'b1, 0);

    // Window 0 holds known values, then two plain calls and a spilling call.
    preload(0, 16'hAAAA);
    preload(1, 16'hBBBB);
    ack_delay = 1;
    op(1'b1, 1'b0, 0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    op(1'b1, 1'b0, 0);
    op(1'b1, 1'b0, 0);
    chk("spill_win3", {62'd0, win}, 64'd3);
    op(1'b0, 1'b1, 0);
    op(1'b0, 1'b1, 0);
    op(1'b0, 1'b1, 0);
    chk("fill_win0", {62'd0, win}, 64'd0);

    // Long ack stall with a call arriving mid-stall.
    op(1'b1, 1'b0, 0);
    op(1'b1, 1'b0, 0);
    ack_delay = 5;
    op(1'b1, 1'b0, 3);

    // Reset while the second spill write is outstanding.
    do_reset();
    ack_delay = 3;
    op(1'b1, 1'b0, 0);
    op(1'b1, 1'b0, 0);
    tick();
    call = 1'b1;
    tick();
    call = 1'b0;
    n = 0;
    while (!(tx_q.size() == 1 && mem_req === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_w1", 64'(n < 100), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_win",  {62'd0, win},     64'd0);
    chk("rst_mid_busy", {63'd0, busy},    64'd0);
    chk("rst_mid_req",  {63'd0, mem_req}, 64'd0);
    rst = 1'b0;
    model_reset();
    tx_q.delete();
    ack_delay = 0;
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 0);

    // Fill the spill stack to its limit; the next call must overflow.
    do_reset();
    for (int i = 0; i < 2 + MAX_SP + 1; i++) op(1'b1, 1'b0, 0);
    chk("overflow_depth", 64'(m_spill), 64'(MAX_SP));

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      ack_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) preload($urandom_range(0, 7), 16'($urandom));
      sel = $urandom_range(0, 99);
      if (sel < 3)       op(1'b1, 1'b1, 0);
      else if (sel < 53) op(1'b1, 1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      else               op(1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
